// File: rtl/hd_bundle_ctrl.sv
// Bundling-counter sequencer: expands one command at a time into registered hd_unit/SCM controls.
// Optional MERGE opcode is built only when HD_BUNDLE_CTRL_MERGE_EN is defined.
package pkg_hd_unit;
  localparam int unsigned BUNDLE_CNTR_WIDTH = 5;
  typedef enum logic [1:0] {
    NOP         = 2'd0,
    PASSTHROUGH = 2'd1,
    BUNDLE      = 2'd2,
    BUNDLE_CTX  = 2'd3
  } operand_sel_e;
  typedef logic [$clog2(BUNDLE_CNTR_WIDTH)-1:0] bundle_ctx_idx_t;
endpackage

module hd_bundle_ctrl #(
  parameter int unsigned BUNDLE_CNTR_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH        = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [2:0]                    cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
  output pkg_hd_unit::operand_sel_e     sel_op_o,
  output logic                          en_bundle_cntr_o,
  output logic                          rst_bundle_cntr_o,
  output logic                          bundle_ctx_we_o,
  output logic                          bundle_ctx_add_o,
  output pkg_hd_unit::bundle_ctx_idx_t  bundle_ctx_idx_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_re_o,
  output logic                          mem_we_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned STEP_W = $clog2(BUNDLE_CNTR_WIDTH + 2);
  typedef logic [STEP_W-1:0]     step_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam step_t LAST_K = step_t'(BUNDLE_CNTR_WIDTH - 1);

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_ACCUM   = 3'd1;
  localparam logic [2:0] OP_THRESH  = 3'd2;
  localparam logic [2:0] OP_SAVE    = 3'd3;
  localparam logic [2:0] OP_RESTORE = 3'd4;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
  localparam logic [2:0] OP_MERGE   = 3'd5;
`endif

  typedef enum logic [1:0] {IDLE, RUN, SAVE_TAIL} state_e;

  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  addr_t      base_q, base_d;
  step_t      step_q, step_d;
  logic       gen;

  pkg_hd_unit::operand_sel_e    sel_q, sel_d;
  pkg_hd_unit::bundle_ctx_idx_t idx_q, idx_d;
  addr_t addr_q, addr_d;
  logic  en_q, en_d, rstc_q, rstc_d, cwe_q, cwe_d;
  logic  re_q, re_d, we_q, we_d, done_q, done_d, err_q, err_d;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
  logic  add_q, add_d;
  step_t merge_k;
`endif

  function automatic logic op_legal(input logic [2:0] op);
`ifdef HD_BUNDLE_CTRL_MERGE_EN
    return (op <= OP_RESTORE) || (op == OP_MERGE);
`else
    return (op <= OP_RESTORE);
`endif
  endfunction

  // Index of the final control cycle spent in RUN for each opcode.
  function automatic step_t last_step(input logic [2:0] op);
    case (op)
      OP_SAVE, OP_RESTORE: last_step = LAST_K;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
      OP_MERGE:            last_step = step_t'(BUNDLE_CNTR_WIDTH);
`endif
      default:             last_step = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    step_d  = step_q;
    gen     = 1'b0;
    sel_d   = pkg_hd_unit::NOP;
    idx_d   = '0;
    addr_d  = '0;
    en_d    = 1'b0;
    rstc_d  = 1'b0;
    cwe_d   = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
    add_d   = 1'b0;
    merge_k = '0;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d   = cmd_op_i;
          base_d = cmd_addr_i;
          step_d = '0;
          if (op_legal(cmd_op_i)) begin
            state_d = RUN;
            gen     = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (step_q == last_step(op_q)) begin
          if (op_q == OP_SAVE) begin
            // The last context bit is written one cycle after it was produced.
            state_d = SAVE_TAIL;
            we_d    = 1'b1;
            addr_d  = base_q + addr_t'(LAST_K);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          step_d = step_q + step_t'(1);
          gen    = 1'b1;
        end
      end
      SAVE_TAIL: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (gen) begin
      case (op_d)
        OP_CLEAR:  rstc_d = 1'b1;
        OP_ACCUM: begin
          re_d   = 1'b1;
          addr_d = base_d;
          sel_d  = pkg_hd_unit::PASSTHROUGH;
          en_d   = 1'b1;
        end
        OP_THRESH: sel_d = pkg_hd_unit::BUNDLE;
        OP_SAVE: begin
          sel_d = pkg_hd_unit::BUNDLE_CTX;
          idx_d = pkg_hd_unit::bundle_ctx_idx_t'(step_d);
          if (step_d != '0) begin
            we_d   = 1'b1;
            addr_d = base_d + addr_t'(step_d) - addr_t'(1);
          end
        end
        OP_RESTORE: begin
          re_d   = 1'b1;
          addr_d = base_d + addr_t'(step_d);
          cwe_d  = 1'b1;
          idx_d  = pkg_hd_unit::bundle_ctx_idx_t'(step_d);
        end
`ifdef HD_BUNDLE_CTRL_MERGE_EN
        OP_MERGE: begin
          if (step_d == '0) begin
            sel_d = pkg_hd_unit::BUNDLE;
          end else begin
            merge_k = step_d - step_t'(1);
            re_d    = 1'b1;
            addr_d  = base_d + addr_t'(merge_k);
            add_d   = 1'b1;
            idx_d   = pkg_hd_unit::bundle_ctx_idx_t'(merge_k);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      base_q  <= '0;
      step_q  <= '0;
      sel_q   <= pkg_hd_unit::NOP;
      idx_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      rstc_q  <= 1'b0;
      cwe_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
      add_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      rstc_q  <= rstc_d;
      cwe_q   <= cwe_d;
      re_q    <= re_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
      add_q   <= add_d;
`endif
    end
  end

  assign cmd_ready_o       = (state_q == IDLE);
  assign sel_op_o          = sel_q;
  assign en_bundle_cntr_o  = en_q;
  assign rst_bundle_cntr_o = rstc_q;
  assign bundle_ctx_we_o   = cwe_q;
  assign bundle_ctx_idx_o  = idx_q;
  assign mem_addr_o        = addr_q;
  assign mem_re_o          = re_q;
  assign mem_we_o          = we_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
`ifdef HD_BUNDLE_CTRL_MERGE_EN
  assign bundle_ctx_add_o  = add_q;
`else
  assign bundle_ctx_add_o  = 1'b0;
`endif

endmodule

// File: doc/hd_bundle_ctrl.md
# hd_bundle_ctrl

Command-driven sequencer for the `hd_unit` array's bundling counters.
- It accepts one bundling command at a time over a valid/ready handshake.
- It expands each command into a cycle-exact sequence of control signals for all `hd_unit`s: `sel_op`, counter enable/reset, and context write/add/index.
- It also drives the SCM row address and read/write strobes.
- It sits between the encoder's main FSM and the `hd_unit` array and SCM. It is the only driver of the bundling-related `hd_unit` controls.

## Interface
Parameters:
- `BUNDLE_CNTR_WIDTH`, default 5: width W of each `hd_unit` bundling counter. Must equal the `pkg_hd_unit` value.
- `ADDR_WIDTH`, default 6: SCM row address width.

Ports:
- `clk_i`  in  1: the single clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `cmd_valid_i`  in  1: command valid.
- `cmd_ready_o`  out  1: controller can accept a command (high only in IDLE).
- `cmd_op_i`  in  3: opcode. 0 CLEAR, 1 ACCUM, 2 THRESH, 3 SAVE, 4 RESTORE, 5 MERGE, 6–7 illegal.
- `cmd_addr_i`  in  ADDR_WIDTH: base SCM row.
- `sel_op_o`  out  `operand_sel_e`: broadcast operation select.
- `en_bundle_cntr_o`, `rst_bundle_cntr_o`, `bundle_ctx_we_o`, `bundle_ctx_add_o`  out  1 each: broadcast counter controls.
- `bundle_ctx_idx_o`  out  `bundle_ctx_idx_t`: counter bit index.
- `mem_addr_o`  out  ADDR_WIDTH: SCM row. The SCM read is combinational, so data reaches `bit_i` in the same cycle.
- `mem_re_o`, `mem_we_o`  out  1 each: SCM read / write (write data is `hd_unit` `result_q`).
- `done_o`  out  1: one-cycle pulse when a command completes.
- `err_o`  out  1: one-cycle pulse on an illegal or disabled opcode.

## Operation
- States: IDLE, RUN, SAVE_TAIL.
- All control outputs are registered.
- Default (IDLE) output values: `sel_op_o`=NOP, every enable/strobe 0, idx 0, addr 0.
- Handshake and counter:
  - A command is accepted when `cmd_valid_i && cmd_ready_o`; opcode and address are latched at that edge.
  - Step counter k runs 0..W-1. Row address is `base + k` mod 2^ADDR_WIDTH (wraps, no error).
- Sequences, one line per control cycle:
  - CLEAR: 1 cycle: `rst_bundle_cntr_o`=1, `sel_op_o`=NOP.
  - ACCUM: 1 cycle: `mem_re_o`=1, addr=base, `sel_op_o`=PASSTHROUGH, `en_bundle_cntr_o`=1. The counter increments/decrements on the read bit.
  - THRESH: 1 cycle: `sel_op_o`=BUNDLE. `result_q` afterwards holds the majority (sign) bit.
  - SAVE: W cycles in RUN, then 1 cycle in SAVE_TAIL.
    - RUN cycle k: `sel_op_o`=BUNDLE_CTX with idx=k.
    - For k≥1, also `mem_we_o`=1 with addr=base+k-1.
    - SAVE_TAIL: `sel_op_o`=NOP, `mem_we_o`=1, addr=base+W-1.
  - RESTORE: W cycles. Cycle k: `mem_re_o`=1, addr=base+k, `bundle_ctx_we_o`=1, idx=k, `sel_op_o`=NOP.
  - MERGE: 1+W cycles.
    - Cycle 0: `sel_op_o`=BUNDLE, which loads the counter MSB into `result_q` for the `hd_unit` saturation check.
    - Cycles 1..W: `mem_re_o`=1, addr=base+k, `bundle_ctx_add_o`=1, idx=k, `sel_op_o`=NOP, for k=0..W-1.
- Illegal opcode:
  - Accepted, no control activity.
  - `err_o` and `done_o` pulse together one cycle after acceptance.
- Exclusivity: at most one of `en_bundle_cntr_o`, `rst_bundle_cntr_o`, `bundle_ctx_we_o`, `bundle_ctx_add_o` is high in any cycle. `mem_re_o` and `mem_we_o` are never both high.

## Timing
- Command accepted at edge t: the first control cycle is t+1.
- For a command of N control cycles (CLEAR/ACCUM/THRESH 1, SAVE W+1, RESTORE W, MERGE W+1):
  - `done_o` pulses in cycle t+N+1, with outputs back to defaults.
  - `cmd_ready_o` is 1 in that same cycle, so back-to-back issue gives a new command's first control cycle at t+N+2.
- `cmd_ready_o` is 0 from t+1 through t+N.
- `cmd_valid_i` while not ready is ignored. The issuer holds it until accepted.
- Reset at any time, including mid-sequence:
  - Immediately returns to IDLE with default outputs.
  - `cmd_ready_o`=1, `done_o`=0, `err_o`=0.
  - The aborted command does not complete, and no further SCM write is issued.

## Configuration
- `HD_BUNDLE_CTRL_MERGE_EN` defined: MERGE (opcode 5) is implemented as above.
- Not defined:
  - MERGE logic is removed and `bundle_ctx_add_o` is tied 0.
  - Opcode 5 behaves as an illegal opcode: no activity, and `err_o` + `done_o` pulse one cycle after acceptance.

## Test plan
- Reset with W=5: `cmd_ready_o`=1, `sel_op_o`=NOP, all strobes 0. Issue CLEAR → `rst_bundle_cntr_o` high exactly at t+1, `done_o` at t+2.
- ACCUM at base 3, then THRESH, back-to-back:
  - ACCUM control at t+1 (`mem_re_o`, addr 3, PASSTHROUGH, `en_bundle_cntr_o`).
  - `done_o` at t+2, with THRESH accepted at t+2.
  - BUNDLE at t+3.
- SAVE at base 62 with W=5:
  - BUNDLE_CTX idx 0..4 in cycles t+1..t+5.
  - `mem_we_o` at t+2..t+6 with addrs 62, 63, 0, 1, 2 (wrap).
  - `done_o` at t+7.
- RESTORE at base 10: addrs 10..14 with `bundle_ctx_we_o` and idx 0..4 over t+1..t+5; `done_o` at t+6. A following SAVE at base 20 writes back identical rows.
- MERGE with macro defined: BUNDLE at t+1, adds idx 0..4 at t+2..t+6, `done_o` at t+7. With the macro undefined: opcode 5 gives `err_o`+`done_o` at t+1 and no strobes.
- Assert `rst_ni` low at cycle t+3 of a SAVE → outputs return to defaults immediately and no `mem_we_o` follows. Opcode 7 → `err_o`+`done_o` at t+1.
